// File: rtl/spi_ram_wrapper_p.sv
// spi_ram_wrapper_p: SPI-framed command interface to a single-port synchronous RAM
module spi_ram_wrapper_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic cmd_err,
  output logic rd_err,
  output logic frame_done
);
  localparam int F  = DATA_W + 3;
  localparam int CW = $clog2(F + 1);
  typedef enum logic [2:0] {IDLE, RX, EXEC, TX, WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [F-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic rd_valid_q, rd_valid_d, armed_q, armed_d, miso_q, miso_d;
  logic cmd_err_q, cmd_err_d, rd_err_q, rd_err_d, done_q, done_d, mem_we;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  logic [2:0] cmd;
  logic [DATA_W-1:0] pay;
  assign cmd = sr_q[F-1 -: 3];
  assign pay = sr_q[DATA_W-1:0];
  assign MISO = miso_q;
  assign cmd_err = cmd_err_q;
  assign rd_err = rd_err_q;
  assign frame_done = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    tx_d = tx_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_valid_d = rd_valid_q;
    armed_d = armed_q | SS_n;
    miso_d = 1'b0;
    cmd_err_d = 1'b0;
    rd_err_d = 1'b0;
    done_d = 1'b0;
    mem_we = 1'b0;
    // Deselect aborts anything in flight; a frame only counts once EXEC is reached with SS_n low
    if (SS_n && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (!SS_n && armed_q) begin
          state_d = RX;
          cnt_d = '0;
        end
        RX: begin
          sr_d = {sr_q[F-2:0], MOSI};
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(F - 1)) ? EXEC : RX;
        end
        EXEC: begin
          done_d = 1'b1;
          state_d = WAIT;
          cnt_d = '0;
          case (cmd)
            3'b000: wr_addr_d = pay[ADDR_W-1:0];
            3'b001: begin
              mem_we = 1'b1;
              if (AUTO_INC != 0) wr_addr_d = wr_addr_q + 1'b1;
            end
            3'b110: begin
              rd_addr_d = pay[ADDR_W-1:0];
              rd_valid_d = 1'b1;
            end
            3'b111: if (rd_valid_q) begin
              tx_d = mem[rd_addr_q];
              state_d = TX;
              if (AUTO_INC != 0) rd_addr_d = rd_addr_q + 1'b1;
              else rd_valid_d = 1'b0;
            end else rd_err_d = 1'b1;
            default: cmd_err_d = 1'b1;
          endcase
        end
        TX: if (cnt_q == CW'(DATA_W)) state_d = WAIT;
        else begin
          miso_d = tx_q[DATA_W-1];
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
        WAIT: state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      tx_q <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_valid_q <= 1'b0;
      armed_q <= 1'b0;
      miso_q <= 1'b0;
      cmd_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      tx_q <= tx_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      armed_q <= armed_d;
      miso_q <= miso_d;
      cmd_err_q <= cmd_err_d;
      rd_err_q <= rd_err_d;
      done_q <= done_d;
    end
  end
  // RAM contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= pay;
  end
endmodule

// File: tb/tb_spi_ram_wrapper_p.sv
// tb_spi_ram_wrapper_p: scoreboard bench for spi_ram_wrapper_p (DATA_W=8, ADDR_W=8, AUTO_INC=1)
module tb_spi_ram_wrapper_p;
  logic clk = 1'b0, rst_n = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, cmd_err, rd_err, frame_done;
  int n_chk = 0, n_bad = 0;
  logic [7:0] m_mem [0:255];
  logic [7:0] m_wa = 8'h00, m_ra = 8'h00;
  logic m_rv = 1'b0;
  logic [7:0] sb [$];

  spi_ram_wrapper_p #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
    .MISO(miso), .cmd_err(cmd_err), .rd_err(rd_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [2:0] c, input logic [7:0] p, input int cut = -1, input int rst_at = -1);
    logic [10:0] w;
    logic [7:0] got;
    logic rd_ok, e_rd, e_cmd;
    w = {c, p};
    got = 8'h00;
    rd_ok = 1'b0;
    e_rd = 1'b0;
    e_cmd = 1'b0;
    ss_n = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) begin
      if (i == cut) begin
        ss_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("abort_pulses", {frame_done, rd_err, cmd_err, miso}, 4'b0000);
        end
        return;
      end
      mosi = w[10-i];
      tick();
      chk("rx_quiet", {frame_done, rd_err, cmd_err, miso}, 4'b0000);
    end
    case (c)
      3'b000: m_wa = p;
      3'b001: begin m_mem[m_wa] = p; m_wa = m_wa + 8'd1; end
      3'b110: begin m_ra = p; m_rv = 1'b1; end
      3'b111: if (m_rv) begin sb.push_back(m_mem[m_ra]); m_ra = m_ra + 8'd1; rd_ok = 1'b1; end
              else e_rd = 1'b1;
      default: e_cmd = 1'b1;
    endcase
    tick();
    chk("exec_pulses", {frame_done, rd_err, cmd_err}, {1'b1, e_rd, e_cmd});
    for (int i = 0; i < (rd_ok ? 9 : 1); i++) begin
      tick();
      if (i == 0) chk("pulse_len", {frame_done, rd_err, cmd_err}, 3'b000);
      if (rd_ok && i < 8) got = {got[6:0], miso};
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_miso", miso, 0);
        chk("rst_flags", {frame_done, rd_err, cmd_err}, 3'b000);
        void'(sb.pop_front());
        m_wa = 8'h00; m_ra = 8'h00; m_rv = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
          mosi = (k == 1);
          tick();
          chk("no_start_after_rst", {frame_done, cmd_err, rd_err, miso}, 4'b0000);
        end
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
        tick();
        return;
      end
    end
    chk("miso_idle", miso, 0);
    if (rd_ok) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("rd_data", got, sb.pop_front());
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #12;
    chk("reset_out", {miso, cmd_err, rd_err, frame_done}, 4'b0000);
    rst_n = 1'b1;
    tick();
    frame(3'b111, 8'h00);
    frame(3'b000, 8'h3C);
    frame(3'b001, 8'hA5);
    frame(3'b110, 8'h3C);
    frame(3'b111, 8'h00);
    frame(3'b000, 8'hFF);
    frame(3'b001, 8'h11);
    frame(3'b001, 8'h22);
    frame(3'b110, 8'hFF);
    frame(3'b111, 8'h00);
    frame(3'b111, 8'h00);
    frame(3'b000, 8'h50);
    frame(3'b001, 8'h5A);
    frame(3'b000, 8'h50);
    frame(3'b001, 8'h77, 8);
    frame(3'b110, 8'h50);
    frame(3'b111, 8'h00);
    frame(3'b001, 8'h66);
    frame(3'b110, 8'h50);
    frame(3'b111, 8'h00);
    frame(3'b110, 8'h3C);
    frame(3'b010, 8'h00);
    frame(3'b011, 8'hFF);
    frame(3'b100, 8'h12);
    frame(3'b101, 8'h34);
    frame(3'b111, 8'h00);
    frame(3'b000, 8'h10);
    frame(3'b001, 8'hFF);
    frame(3'b110, 8'h10);
    frame(3'b111, 8'h00, -1, 3);
    frame(3'b111, 8'h00);
    if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
